// File: rtl/wshb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wshb_arb_pkg;

  localparam int NB_MASTERS = 2;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/wshb_arb_mux.sv
// Combinational master-to-slave request mux and slave-to-master ack demux,
// steered by a one-hot grant vector.
module wshb_arb_mux #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic [1:0]          gnt,
  input  logic                m0_cyc,
  input  logic                m0_stb,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_adr,
  input  logic [DATA_W-1:0]   m0_dat_w,
  input  logic [DATA_W/8-1:0] m0_sel,
  output logic                m0_ack,
  input  logic                m1_cyc,
  input  logic                m1_stb,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_adr,
  input  logic [DATA_W-1:0]   m1_dat_w,
  input  logic [DATA_W/8-1:0] m1_sel,
  output logic                m1_ack,
  output logic [DATA_W-1:0]   m_dat_r,
  output logic                s_cyc,
  output logic                s_stb,
  output logic                s_we,
  output logic [ADDR_W-1:0]   s_adr,
  output logic [DATA_W-1:0]   s_dat_w,
  output logic [DATA_W/8-1:0] s_sel,
  input  logic                s_ack,
  input  logic [DATA_W-1:0]   s_dat_r
);

  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_dat_w = '0;
    s_sel   = '0;
    if (gnt[0]) begin
      s_cyc   = m0_cyc;
      s_stb   = m0_stb;
      s_we    = m0_we;
      s_adr   = m0_adr;
      s_dat_w = m0_dat_w;
      s_sel   = m0_sel;
    end else if (gnt[1]) begin
      s_cyc   = m1_cyc;
      s_stb   = m1_stb;
      s_we    = m1_we;
      s_adr   = m1_adr;
      s_dat_w = m1_dat_w;
      s_sel   = m1_sel;
    end
  end

  // Acks follow the grant only, so a stray s_ack while idle reaches nobody.
  assign m0_ack  = s_ack & gnt[0];
  assign m1_ack  = s_ack & gnt[1];
  assign m_dat_r = s_dat_r;

endmodule

// File: rtl/wshb_arbiter.sv
// Two-master, one-slave Wishbone classic arbiter (VGA reader vs. mire
// generator) with bus-cycle-long grants and fixed or round-robin priority.
module wshb_arbiter
  import wshb_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIXED_PRIO = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_cyc,
  input  logic                m0_stb,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_adr,
  input  logic [DATA_W-1:0]   m0_dat_w,
  input  logic [DATA_W/8-1:0] m0_sel,
  output logic                m0_ack,
  input  logic                m1_cyc,
  input  logic                m1_stb,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_adr,
  input  logic [DATA_W-1:0]   m1_dat_w,
  input  logic [DATA_W/8-1:0] m1_sel,
  output logic                m1_ack,
  output logic [DATA_W-1:0]   m_dat_r,
  output logic                s_cyc,
  output logic                s_stb,
  output logic                s_we,
  output logic [ADDR_W-1:0]   s_adr,
  output logic [DATA_W-1:0]   s_dat_w,
  output logic [DATA_W/8-1:0] s_sel,
  input  logic                s_ack,
  input  logic [DATA_W-1:0]   s_dat_r
);

  arb_state_t              state_reg, state_next;
  logic                    last_grant_reg, last_grant_next;
  logic [NB_MASTERS-1:0]   gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
    end
  end

  // Grants always pass through IDLE, so the slave sees s_cyc low between owners.
  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    case (state_reg)
      IDLE: begin
        if (m0_cyc && m1_cyc) begin
          if (FIXED_PRIO != 0 || last_grant_reg) state_next = GNT0;
          else                                   state_next = GNT1;
        end else if (m0_cyc) begin
          state_next = GNT0;
        end else if (m1_cyc) begin
          state_next = GNT1;
        end
      end
      GNT0:    if (!m0_cyc) state_next = IDLE;
      GNT1:    if (!m1_cyc) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (state_reg == IDLE && state_next == GNT0) last_grant_next = 1'b0;
    if (state_reg == IDLE && state_next == GNT1) last_grant_next = 1'b1;
  end

  always_comb begin
    gnt = '0;
    case (state_reg)
      GNT0:    gnt = 2'b01;
      GNT1:    gnt = 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  wshb_arb_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mux (
    .gnt      (gnt),
    .m0_cyc   (m0_cyc),
    .m0_stb   (m0_stb),
    .m0_we    (m0_we),
    .m0_adr   (m0_adr),
    .m0_dat_w (m0_dat_w),
    .m0_sel   (m0_sel),
    .m0_ack   (m0_ack),
    .m1_cyc   (m1_cyc),
    .m1_stb   (m1_stb),
    .m1_we    (m1_we),
    .m1_adr   (m1_adr),
    .m1_dat_w (m1_dat_w),
    .m1_sel   (m1_sel),
    .m1_ack   (m1_ack),
    .m_dat_r  (m_dat_r),
    .s_cyc    (s_cyc),
    .s_stb    (s_stb),
    .s_we     (s_we),
    .s_adr    (s_adr),
    .s_dat_w  (s_dat_w),
    .s_sel    (s_sel),
    .s_ack    (s_ack),
    .s_dat_r  (s_dat_r)
  );

endmodule

// File: tb/tb_wshb_arbiter.sv
// Bench for wshb_arbiter: a round-robin and a fixed-priority instance share
// the same master stimulus and are checked against a bus-ownership model.
module tb_wshb_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic          rst;
  logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [AW-1:0] m0_adr, m1_adr;
  logic [DW-1:0] m0_dat_w, m1_dat_w, s_dat_r;
  logic [SW-1:0] m0_sel, m1_sel;
  logic          s_ack, s_ack_reg;
  logic [1:0]    ack_src;

  // index 0 = round-robin instance, index 1 = fixed-priority instance
  logic [1:0]          o_cyc, o_stb, o_we, o_a0, o_a1;
  logic [1:0][AW-1:0]  o_adr;
  logic [1:0][DW-1:0]  o_dat_w, o_dat_r;
  logic [1:0][SW-1:0]  o_sel;

  // The slave can be a free-running bench signal or answer every strobe of one instance.
  assign s_ack = (ack_src == 2'd0) ? s_ack_reg :
                 (ack_src == 2'd1) ? (o_cyc[0] & o_stb[0]) : (o_cyc[1] & o_stb[1]);

  wshb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_w(m0_dat_w), .m0_sel(m0_sel), .m0_ack(o_a0[0]),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_w(m1_dat_w), .m1_sel(m1_sel), .m1_ack(o_a1[0]),
    .m_dat_r(o_dat_r[0]),
    .s_cyc(o_cyc[0]), .s_stb(o_stb[0]), .s_we(o_we[0]), .s_adr(o_adr[0]),
    .s_dat_w(o_dat_w[0]), .s_sel(o_sel[0]), .s_ack(s_ack), .s_dat_r(s_dat_r)
  );

  wshb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1)) u_fp (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_w(m0_dat_w), .m0_sel(m0_sel), .m0_ack(o_a0[1]),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_w(m1_dat_w), .m1_sel(m1_sel), .m1_ack(o_a1[1]),
    .m_dat_r(o_dat_r[1]),
    .s_cyc(o_cyc[1]), .s_stb(o_stb[1]), .s_we(o_we[1]), .s_adr(o_adr[1]),
    .s_dat_w(o_dat_w[1]), .s_sel(o_sel[1]), .s_ack(s_ack), .s_dat_r(s_dat_r)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who owns the bus (0, 1, or 2 = nobody) and who had it last.
  int own_m [2];
  int last_m[2];
  logic model_en = 1'b0;

  function automatic int pick(input int fixed, input int last);
    if (!m0_cyc && !m1_cyc) return 2;
    if (!m1_cyc) return 0;
    if (!m0_cyc) return 1;
    return (fixed != 0) ? 0 : 1 - last;
  endfunction

  function automatic logic owner_cyc(input int own);
    return (own == 0) ? m0_cyc : m1_cyc;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        own_m[i]  <= 2;
        last_m[i] <= 1;
      end else if (own_m[i] == 2) begin
        own_m[i] <= pick(i, last_m[i]);
        if (pick(i, last_m[i]) != 2) last_m[i] <= pick(i, last_m[i]);
      end else if (!owner_cyc(own_m[i])) begin
        own_m[i] <= 2;
      end
    end
    if (rst) model_en <= 1'b1;
  end

  function automatic logic [127:0] expect_out(input int own);
    logic [127:0] v;
    v = '0;
    if (own == 0)
      v = {23'd0, m0_cyc, m0_stb, m0_we, m0_adr, m0_dat_w, m0_sel, s_ack, 1'b0, s_dat_r};
    else if (own == 1)
      v = {23'd0, m1_cyc, m1_stb, m1_we, m1_adr, m1_dat_w, m1_sel, 1'b0, s_ack, s_dat_r};
    else
      v = {23'd0, 3'b000, {AW{1'b0}}, {DW{1'b0}}, {SW{1'b0}}, 2'b00, s_dat_r};
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  task automatic sample();
    logic [127:0] act;
    @(negedge clk);
    if (model_en) begin
      for (int i = 0; i < 2; i++) begin
        act = {23'd0, o_cyc[i], o_stb[i], o_we[i], o_adr[i], o_dat_w[i], o_sel[i],
               o_a0[i], o_a1[i], o_dat_r[i]};
        chk((i == 0) ? "model_rr" : "model_fp", act, expect_out(own_m[i]));
      end
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic c0, input logic c1);
    rst = r; m0_cyc = c0; m0_stb = c0; m1_cyc = c1; m1_stb = c1;
  endtask

  typedef struct packed {
    logic       rst, c0, c1, ack, chk;
    logic [1:0] g_rr, g_fp;   // expected owner: 0 none, 1 master0, 2 master1
  } vec_t;

  function automatic vec_t mk(input logic r, c0, c1, a, ck, input logic [1:0] grr, gfp);
    vec_t v;
    v.rst = r; v.c0 = c0; v.c1 = c1; v.ack = a; v.chk = ck; v.g_rr = grr; v.g_fp = gfp;
    return v;
  endfunction

  function automatic logic [127:0] tbl_exp(input vec_t v, input logic [1:0] g);
    if (g == 2'd1) return {93'd0, v.c0, v.ack, 1'b0, 32'h0000_0100};
    if (g == 2'd2) return {93'd0, v.c1, 1'b0, v.ack, 32'h0000_0200};
    return '0;
  endfunction

  vec_t tbl[33];

  initial begin
    int n0, n1, drop0, drop1, cyc_n, last_ack_cyc, gap, m1_early;
    logic m1_done;
    int order[$];

    tbl[0]  = mk(1,0,0,0,0, 0,0);  tbl[1]  = mk(1,0,0,0,1, 0,0);
    tbl[2]  = mk(1,0,0,1,1, 0,0);  tbl[3]  = mk(0,1,0,0,1, 0,0);
    tbl[4]  = mk(0,1,0,0,1, 1,1);  tbl[5]  = mk(0,1,0,1,1, 1,1);
    tbl[6]  = mk(0,0,0,0,1, 1,1);  tbl[7]  = mk(0,0,0,0,1, 0,0);
    tbl[8]  = mk(1,0,0,0,1, 0,0);  tbl[9]  = mk(0,1,1,0,1, 0,0);
    tbl[10] = mk(0,1,1,0,1, 1,1);  tbl[11] = mk(0,0,1,0,1, 1,1);
    tbl[12] = mk(0,0,1,0,1, 0,0);  tbl[13] = mk(0,0,1,0,1, 2,2);
    tbl[14] = mk(0,0,1,1,1, 2,2);  tbl[15] = mk(0,1,0,0,1, 2,2);
    tbl[16] = mk(0,1,0,0,1, 0,0);  tbl[17] = mk(0,0,1,0,1, 1,1);
    tbl[18] = mk(0,1,1,0,1, 0,0);  tbl[19] = mk(0,1,1,0,1, 2,1);
    tbl[20] = mk(0,0,0,1,1, 2,1);  tbl[21] = mk(0,0,0,1,1, 0,0);
    tbl[22] = mk(0,0,0,0,1, 0,0);  tbl[23] = mk(0,1,0,0,1, 0,0);
    tbl[24] = mk(0,0,0,0,1, 1,1);  tbl[25] = mk(0,0,0,0,1, 0,0);
    tbl[26] = mk(0,0,1,0,1, 0,0);  tbl[27] = mk(0,0,1,0,1, 2,2);
    tbl[28] = mk(1,0,1,1,1, 2,2);  tbl[29] = mk(0,1,1,1,1, 0,0);
    tbl[30] = mk(0,1,1,0,1, 1,1);  tbl[31] = mk(0,0,0,0,1, 1,1);
    tbl[32] = mk(0,0,0,0,1, 0,0);

    rst = 1'b1; drive(1, 0, 0);
    m0_we = 1'b0; m1_we = 1'b0;
    m0_adr = 32'h100; m1_adr = 32'h200;
    m0_dat_w = 32'hA0A0_0000; m1_dat_w = 32'hB1B1_1111;
    m0_sel = 4'hF; m1_sel = 4'h3;
    s_ack_reg = 1'b0; ack_src = 2'd0; s_dat_r = 32'hCAFE_0001;
    next();

    // Table phase: single request, simultaneous request, withdrawal, reset mid-burst.
    for (int r = 0; r < 33; r++) begin
      drive(tbl[r].rst, tbl[r].c0, tbl[r].c1);
      s_ack_reg = tbl[r].ack;
      sample();
      if (tbl[r].chk) begin
        chk($sformatf("tbl%0d_rr", r), {93'd0, o_cyc[0], o_a0[0], o_a1[0], o_adr[0]},
            tbl_exp(tbl[r], tbl[r].g_rr));
        chk($sformatf("tbl%0d_fp", r), {93'd0, o_cyc[1], o_a0[1], o_a1[1], o_adr[1]},
            tbl_exp(tbl[r], tbl[r].g_fp));
      end
      next();
    end

    // Alternation under round-robin: both masters re-request 4 times.
    drive(1, 0, 0); sample(); next();
    ack_src = 2'd1; n0 = 0; n1 = 0; drop0 = 0; drop1 = 0;
    for (int c = 0; c < 200 && (n0 < 4 || n1 < 4); c++) begin
      drive(0, (n0 < 4) && drop0 == 0, (n1 < 4) && drop1 == 0);
      sample();
      drop0 = 0; drop1 = 0;
      if (o_a0[0]) begin order.push_back(0); n0++; drop0 = 1; end
      if (o_a1[0]) begin order.push_back(1); n1++; drop1 = 1; end
      next();
    end
    chk("alt_count", 128'(order.size()), 128'd8);
    for (int k = 0; k < 8 && k < order.size(); k++)
      chk($sformatf("alt_order%0d", k), 128'(order[k]), 128'(k % 2));

    // Fixed priority: master 0 re-requests one cycle after each release.
    drive(1, 0, 0); sample(); next();
    ack_src = 2'd2; n0 = 0; drop0 = 0; m1_done = 1'b0; m1_early = 0;
    cyc_n = 0; last_ack_cyc = 0; gap = -1;
    for (int c = 0; c < 100 && !m1_done; c++) begin
      drive(0, (n0 < 5) && drop0 == 0, 1'b1);
      sample();
      cyc_n++;
      drop0 = 0;
      if (o_a0[1]) begin n0++; drop0 = 1; last_ack_cyc = cyc_n; end
      if (o_a1[1]) begin
        if (n0 < 5) m1_early++;
        else begin m1_done = 1'b1; gap = cyc_n - last_ack_cyc; end
      end
      next();
    end
    chk("fp_m1_while_m0", 128'(m1_early), 128'd0);
    chk("fp_m1_served", 128'(m1_done), 128'd1);
    chk("fp_m1_gap", 128'(gap), 128'd3);

    // Long burst on master 1 while master 0 waits: no preemption.
    drive(1, 0, 0); sample(); next();
    ack_src = 2'd1; n1 = 0;
    drive(0, 0, 1); sample(); next();
    for (int c = 0; c < 100 && n1 < 64; c++) begin
      drive(0, 1, 1);
      sample();
      if (o_a1[0]) n1++;
      chk("burst_m0_ack", 128'({o_a0[0], o_a0[1]}), 128'd0);
      chk("burst_adr", 128'(o_adr[0]), 128'(m1_adr));
      next();
    end
    chk("burst_len", 128'(n1), 128'd64);
    drive(0, 1, 0); sample();
    chk("rel_t0_cyc", 128'(o_cyc[0]), 128'd0); next();
    sample();
    chk("rel_t1_cyc", 128'(o_cyc[0]), 128'd0); next();
    sample();
    chk("rel_t2_grant", {95'd0, o_cyc[0], o_adr[0]}, {95'd0, 1'b1, m0_adr}); next();
    drive(0, 0, 0); sample(); next();

    // Randomized traffic against the model.
    ack_src = 2'd0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 3) == 0) m0_cyc = ~m0_cyc;
      if ($urandom_range(0, 3) == 0) m1_cyc = ~m1_cyc;
      m0_stb = 1'($urandom); m1_stb = 1'($urandom);
      m0_we = 1'($urandom); m1_we = 1'($urandom);
      m0_adr = $urandom; m1_adr = $urandom;
      m0_dat_w = $urandom; m1_dat_w = $urandom;
      m0_sel = 4'($urandom); m1_sel = 4'($urandom);
      s_ack_reg = 1'($urandom); s_dat_r = $urandom;
      sample();
      next();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wshb_arbiter.md
Name: wshb_arbiter

Overview:
- Two-master, one-slave Wishbone (classic, 32-bit) arbiter that shares the SDRAM slave port between the VGA frame reader (master 0) and the pattern generator "mire" (master 1).
- Sits inside Top between the two masters and the hws_if SDRAM bridge, in the 50 MHz system clock domain.
- Grant is held for a whole bus cycle, i.e. while the granted master keeps cyc high.
- Selectable fixed-priority or round-robin policy.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width; SEL width is DATA_W/8.
- FIXED_PRIO, 0, 0 = round-robin; 1 = master 0 always wins ties.

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  synchronous active-high reset
- m0_cyc, m0_stb, m0_we  in  1 each  master 0 (VGA) request
- m0_adr  in  ADDR_W  master 0 address
- m0_dat_w  in  DATA_W  master 0 write data
- m0_sel  in  DATA_W/8  master 0 byte select
- m0_ack  out  1  master 0 acknowledge
- m1_cyc, m1_stb, m1_we, m1_adr, m1_dat_w, m1_sel  in  as m0  master 1 (mire) request
- m1_ack  out  1  master 1 acknowledge
- m_dat_r  out  DATA_W  read data, broadcast to both masters
- s_cyc, s_stb, s_we  out  1 each  slave request
- s_adr  out  ADDR_W  slave address
- s_dat_w  out  DATA_W  slave write data
- s_sel  out  DATA_W/8  slave byte select
- s_ack  in  1  slave acknowledge
- s_dat_r  in  DATA_W  slave read data

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst).
- FSM states: IDLE, GNT0, GNT1. Registered state; reset state is IDLE. last_grant register resets to 1, so master 0 wins the first tie.
- IDLE transitions:
  - only m0_cyc → GNT0
  - only m1_cyc → GNT1
  - both requesting, FIXED_PRIO=1 → GNT0
  - both requesting, FIXED_PRIO=0 → the master that is not last_grant
  - neither → stay in IDLE
- GNTx transitions:
  - stay while mx_cyc=1
  - mx_cyc=0 → IDLE
  - last_grant ← x on entry
- Output muxing is combinational from the registered state and the granted master's inputs:
  - In GNTx: s_cyc=mx_cyc, s_stb=mx_stb; s_we, s_adr, s_dat_w, s_sel copy master x.
  - In IDLE: s_cyc=s_stb=s_we=0; s_adr, s_dat_w, s_sel=0.
- Ack routing:
  - mx_ack = s_ack & (state==GNTx).
  - The non-granted master's ack is always 0.
  - m_dat_r = s_dat_r unconditionally.
- Latency:
  - Request in IDLE at edge t → grant visible after edge t+1; s_cyc high in the same cycle.
  - Release: master drops cyc in cycle t → s_cyc low combinationally in cycle t; IDLE from t+1; next grant earliest from t+2.
  - The mandatory one IDLE cycle between grants is required, so the slave always sees s_cyc low for at least 1 cycle between owners.
- No preemption: a master keeps the bus for any burst length. Fairness comes only from alternation at release in round-robin mode.
- Boundary cases:
  - Request withdrawn during the IDLE decision cycle: the grant is still taken. s_cyc follows mx_cyc=0, and the FSM returns to IDLE next cycle.
  - s_ack while in IDLE is ignored; no ack goes to any master.
  - rst during a transfer: state → IDLE and last_grant → 1 at the next edge. All s_* control outputs and both acks are 0 from that edge on, regardless of s_ack.
- Reset values, observed with masters idle: s_cyc=s_stb=s_we=0, s_adr=s_dat_w=s_sel=0, m0_ack=m1_ack=0.

Decomposition:
- Shared package wshb_arb_pkg:
  - typedef enum logic [1:0] {IDLE, GNT0, GNT1} arb_state_t
  - constants NB_MASTERS=2 and default widths
- Optional sub-module: wshb_arb_mux, the purely combinational master→slave mux and ack demux driven by the state.
- FSM and last_grant stay in wshb_arbiter.

Test Plan:
- Reset, then single request: rst=1 for 3 cycles, then m0_cyc=m0_stb=1, adr=0x100, s_ack at the 2nd granted cycle → s_adr=0x100, m0_ack pulses 1 cycle, m1_ack=0 throughout.
- Simultaneous request, round-robin: m0_cyc and m1_cyc rise on the same edge (FIXED_PRIO=0) → GNT0 first. After m0 drops cyc: 1 IDLE cycle, then GNT1, s_adr switches to m1_adr.
- Alternation: both masters keep re-requesting 4 transactions each (FIXED_PRIO=0) → grant order 0,1,0,1,0,1,0,1, one IDLE cycle between each.
- Fixed priority: FIXED_PRIO=1, both requesting continuously with m0 re-asserting cyc one cycle after release → m1 never granted while m0 requests; m1 granted on the first IDLE where m0_cyc=0.
- Long burst, no preemption: m1 holds cyc for 64 cycles with 64 acks while m0 requests → m0_ack=0 and s_adr=m1_adr throughout; m0 granted 2 cycles after m1_cyc falls.
- Reset mid-burst: assert rst while GNT1 with s_ack=1 → from the next edge s_cyc=0 and m1_ack=0; after release of rst with both requesting, master 0 is granted first.
